uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
//
// Turns a stream of received ASCII bytes into one-cycle control pulses for a
// counter: run/stop toggle, clear, up/down mode toggle and a decimal preset
// load ("S" + 1..4 digits + CR). Malformed input and a stalled set command
// produce an error pulse. Every response is registered and appears exactly
// one clock after the rx_valid cycle that caused it.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   rx_valid    one-cycle strobe: rx_data holds a new byte
//   rx_data     received ASCII byte
//   o_run_stop  pulse: toggle counter run/stop
//   o_clear     pulse: clear counter
//   o_mode      pulse: toggle up/down mode
//   o_load      pulse: o_load_val is a new preset
//   o_load_val  preset value, held until the next load
//   o_err       pulse: malformed command or set-command timeout
// ---------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter int MAX_VAL     = 9999,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        o_run_stop,
    output logic        o_clear,
    output logic        o_mode,
    output logic        o_load,
    output logic [13:0] o_load_val,
    output logic        o_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [13:0]   MAX_V  = 14'(MAX_VAL);

    typedef enum logic {IDLE, SET} state_t;

    state_t        state, state_d;
    logic [13:0]   acc, acc_d;
    logic [2:0]    cnt, cnt_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [13:0]   load_val_d;
    logic          run_d, clear_d, mode_d, load_d, err_d;

    logic          is_digit;
    logic [13:0]   digit;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign digit    = {10'd0, rx_data[3:0]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state;
        acc_d      = acc;
        cnt_d      = cnt;
        tcnt_d     = tcnt;
        load_val_d = o_load_val;
        run_d      = 1'b0;
        clear_d    = 1'b0;
        mode_d     = 1'b0;
        load_d     = 1'b0;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h52, 8'h72: run_d   = 1'b1;   // R r
                        8'h43, 8'h63: clear_d = 1'b1;   // C c
                        8'h4D, 8'h6D: mode_d  = 1'b1;   // M m
                        8'h53, 8'h73: begin             // S s
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = SET;
                        end
                        8'h0D, 8'h0A, 8'h20: ;          // CR LF space
                        default:      err_d   = 1'b1;
                    endcase
                end
            end

            SET: begin
                if (rx_valid) begin
                    // A received byte always wins over a timeout in the same cycle.
                    tcnt_d = '0;
                    if (is_digit) begin
                        if (cnt < 3'd4) begin
                            // acc <= 999 here, so acc*10+9 fits in 14 bits.
                            acc_d = acc * 14'd10 + digit;
                            cnt_d = cnt + 3'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (rx_data == 8'h0D) begin
                        state_d = IDLE;
                        if (cnt != 3'd0 && acc <= MAX_V) begin
                            load_d     = 1'b1;
                            load_val_d = acc;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tcnt == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // The timeout counter only runs while a set command is open.
        if (state_d == IDLE) tcnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state, including the datapath registers, is reset so a
        // partial command can never leak past a reset.
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            o_load_val <= '0;
            o_run_stop <= 1'b0;
            o_clear    <= 1'b0;
            o_mode     <= 1'b0;
            o_load     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this edge.
            state      <= state_d;
            acc        <= acc_d;
            cnt        <= cnt_d;
            tcnt       <= tcnt_d;
            o_load_val <= load_val_d;
            o_run_stop <= run_d;
            o_clear    <= clear_d;
            o_mode     <= mode_d;
            o_load     <= load_d;
            o_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
//
// Self-checking bench for uart_cmd_decoder (MAX_VAL=5000, TIMEOUT_CYC=16).
// A command-level reference model tracks the open set command as a list of
// digits plus an idle-cycle count and predicts the registered outputs; a
// compare process checks the DUT against it every cycle. Directed sequences
// pin the model with literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    localparam int MAXV = 5000;
    localparam int TCYC = 16;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        o_run_stop, o_clear, o_mode, o_load, o_err;
    logic [13:0] o_load_val;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_decoder #(.MAX_VAL(MAXV), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .o_run_stop (o_run_stop),
        .o_clear    (o_clear),
        .o_mode     (o_mode),
        .o_load     (o_load),
        .o_load_val (o_load_val),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_in_set;
    int          m_digits[$];
    int          m_idle;
    logic        e_run, e_clr, e_mode, e_load, e_err;
    logic [13:0] e_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in_set = 0;
            m_digits.delete();
            m_idle = 0;
            {e_run, e_clr, e_mode, e_load, e_err} = '0;
            e_val = '0;
        end else begin
            {e_run, e_clr, e_mode, e_load, e_err} = '0;
            if (!m_in_set) begin
                if (rx_valid) begin
                    case (rx_data)
                        "R", "r": e_run  = 1;
                        "C", "c": e_clr  = 1;
                        "M", "m": e_mode = 1;
                        "S", "s": begin
                            m_in_set = 1;
                            m_digits.delete();
                            m_idle = 0;
                        end
                        8'h0D, 8'h0A, 8'h20: ;
                        default: e_err = 1;
                    endcase
                end
            end else if (rx_valid) begin
                m_idle = 0;
                if (rx_data >= "0" && rx_data <= "9") begin
                    if (m_digits.size() == 4) begin
                        e_err = 1;
                        m_in_set = 0;
                    end else begin
                        m_digits.push_back(int'(rx_data) - 48);
                    end
                end else if (rx_data == 8'h0D) begin
                    int v;
                    v = 0;
                    foreach (m_digits[i]) v = v * 10 + m_digits[i];
                    m_in_set = 0;
                    if (m_digits.size() > 0 && v <= MAXV) begin
                        e_load = 1;
                        e_val  = 14'(v);
                    end else begin
                        e_err = 1;
                    end
                end else begin
                    e_err = 1;
                    m_in_set = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TCYC) begin
                    e_err = 1;
                    m_in_set = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("model_cmp",
              32'({o_run_stop, o_clear, o_mode, o_load, o_err, o_load_val}),
              32'({e_run, e_clr, e_mode, e_load, e_err, e_val}));
        check("one_hot", 32'($countones({o_run_stop, o_clear, o_mode, o_load, o_err}) <= 1), 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Byte then one idle cycle; on return the outputs show the response.
    task automatic send(input logic [7:0] b);
        drive_byte(b);
        drive_idle(1);
    endtask

    function automatic logic [4:0] pulses();
        return {o_run_stop, o_clear, o_mode, o_load, o_err};
    endfunction

    logic [7:0] tok [16];

    initial begin
        tok = '{"S", "s", "R", "r", "C", "c", "M", "m",
                8'h0D, 8'h0A, 8'h20, "0", "5", "9", "x", 8'hFF};
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({pulses(), o_load_val}), 32'd0);

        // First byte accepted on the first edge after release; 'R' response.
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = "R";
        @(negedge clk);
        rx_valid = 1'b0;
        check("R_run_stop", 32'(pulses()), 32'b10000);
        @(negedge clk);
        check("R_one_cycle", 32'(pulses()), 32'd0);

        // S1234 CR -> load 1234, then 'c' -> clear, value held.
        send("S"); check("S_no_pulse", 32'(pulses()), 32'd0);
        send("1"); send("2"); send("3"); send("4");
        check("digits_no_pulse", 32'(pulses()), 32'd0);
        send(8'h0D);
        check("load_pulse", 32'(pulses()), 32'b00010);
        check("load_val_1234", 32'(o_load_val), 32'd1234);
        send("c");
        check("clear_pulse", 32'(pulses()), 32'b01000);
        check("load_val_held", 32'(o_load_val), 32'd1234);

        // Leading zeros.
        send("s"); send("0"); send("0"); send("4"); send("2"); send(8'h0D);
        check("load_val_42", 32'(o_load_val), 32'd42);

        // S CR -> error, value unchanged.
        send("S"); send(8'h0D);
        check("empty_set_err", 32'(pulses()), 32'b00001);
        check("empty_set_val", 32'(o_load_val), 32'd42);

        // Fifth digit -> error, back in IDLE (a digit then errors).
        send("S"); send("1"); send("2"); send("3"); send("4"); send("5");
        check("fifth_digit_err", 32'(pulses()), 32'b00001);
        send("1");
        check("idle_digit_err", 32'(pulses()), 32'b00001);

        // Above MAX_VAL -> error, value unchanged.
        send("S"); send("6"); send("0"); send("0"); send("0"); send(8'h0D);
        check("over_max_err", 32'(pulses()), 32'b00001);
        check("over_max_val", 32'(o_load_val), 32'd42);

        // Exactly MAX_VAL is accepted.
        send("S"); send("5"); send("0"); send("0"); send("0"); send(8'h0D);
        check("max_val_load", 32'({pulses(), o_load_val}), 32'({5'b00010, 14'd5000}));

        // Timeout: fires after 16 idle cycles, not before.
        drive_byte("S"); drive_byte("7"); rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        repeat (TCYC - 1) begin
            @(negedge clk);
            check("timeout_early", 32'(o_err), 32'd0);
        end
        @(negedge clk);
        check("timeout_err", 32'(pulses()), 32'b00001);
        send("M");
        check("mode_after_timeout", 32'(pulses()), 32'b00100);

        // Reset mid-SET discards the command.
        send("S"); send("9");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(8'h0D);
        check("post_reset_quiet", 32'({pulses(), o_load_val}), 32'd0);

        // Bad byte vs ignored whitespace in IDLE.
        send("x");    check("x_err", 32'(pulses()), 32'b00001);
        send(8'h0A);  check("lf_ignored", 32'(pulses()), 32'd0);
        send(8'h20);  check("space_ignored", 32'(pulses()), 32'd0);

        // Back-to-back bytes count as separate bytes.
        drive_byte("S"); drive_byte("3"); drive_byte("1"); drive_byte(8'h0D);
        drive_idle(1);
        check("b2b_load", 32'({pulses(), o_load_val}), 32'({5'b00010, 14'd31}));

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                drive_byte(tok[$urandom_range(0, 15)]);
            end else if (kind < 9) begin
                int nd;
                nd = $urandom_range(0, 5);
                drive_byte(($urandom_range(0, 1) != 0) ? 8'h53 : 8'h73);
                for (int d = 0; d < nd; d++) begin
                    drive_byte(8'(8'h30 + $urandom_range(0, 9)));
                    if ($urandom_range(0, 3) == 0) drive_idle($urandom_range(1, 4));
                end
                drive_byte(($urandom_range(0, 4) != 0) ? 8'h0D : tok[$urandom_range(0, 15)]);
            end else begin
                @(negedge clk); rst = 1'b0; rx_valid = 1'b0;
                drive_idle($urandom_range(1, 3));
                rst = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) drive_idle(TCYC + 2);
            else drive_idle($urandom_range(0, 2));
        end
        drive_idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
